mips_instr_encoder: RTL

- Encoder/writer counterpart of the main control decoder: accepts symbolic instruction requests (kind + register/immediate fields), packs them into 32-bit MIPS words and writes them sequentially into instruction memory.
- Used as a boot/program loader and by testbenches to fill imem before the single-cycle core is released from reset.
- Covers exactly the instruction subset the decoder supports: ADD, SUB, AND, OR, SLT, LW, SW, BEQ.

---
 rtl/mips_instr_encoder.sv | 118 +++++++++++
 1 files changed

// File: rtl/mips_instr_encoder.sv
// Packs symbolic ADD/SUB/AND/OR/SLT/LW/SW/BEQ requests into MIPS words and writes them to imem in order; ENC_CHECKSUM_EN adds an XOR checksum.
// Latency: a request accepted at edge N is written (imem_we=1) during cycle N+1, so one word is written every 2 cycles.
// Backpressure: in_ready is high only in IDLE and stays low after done/err_full until rst or clear.
module mips_instr_encoder #(
   parameter int IMEM_DEPTH = 64,
   parameter int ADDR_W     = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_kind,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [15:0]       in_imm,
   input  logic              in_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              done,
   output logic              err_full,
   output logic [31:0]       checksum
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
   localparam logic [1:0] S_FULL  = 2'd3;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

   logic [1:0]        state;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W:0]   cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              last_q;
   logic [31:0]       enc;
   logic              restart;

   assign restart = rst | clear;

   always_comb begin
      enc = '0;
      case (in_kind)
         3'd0:    enc = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100000};
         3'd1:    enc = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100010};
         3'd2:    enc = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100100};
         3'd3:    enc = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100101};
         3'd4:    enc = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b101010};
         3'd5:    enc = {6'b100011, in_rs, in_rt, in_imm};
         3'd6:    enc = {6'b101011, in_rs, in_rt, in_imm};
         default: enc = {6'b000100, in_rs, in_rt, in_imm};
      endcase
   end

   always_ff @(posedge clk) begin
      if (restart) begin
         state   <= S_IDLE;
         ptr     <= '0;
         cnt     <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         last_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  wdata_q <= enc;
                  addr_q  <= ptr;
                  last_q  <= in_last;
                  state   <= S_WRITE;
               end
            end
            S_WRITE: begin
               ptr <= ptr + 1'b1;
               cnt <= cnt + 1'b1;
               // a last word at the top address still counts as a clean finish
               if (last_q)
                  state <= S_DONE;
               else if (ptr == LAST_ADDR)
                  state <= S_FULL;
               else
                  state <= S_IDLE;
            end
            default: ;
         endcase
      end
   end

   // gating by restart drops a pending write in the same cycle it is aborted
   assign imem_we    = (state == S_WRITE) & ~restart;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign count      = cnt;
   assign in_ready   = (state == S_IDLE);
   assign done       = (state == S_DONE);
   assign err_full   = (state == S_FULL);

`ifdef ENC_CHECKSUM_EN
   logic [31:0] csum_q;

   always_ff @(posedge clk) begin
      if (restart)
         csum_q <= '0;
      else if (state == S_WRITE)
         csum_q <= csum_q ^ wdata_q;
   end

   assign checksum = csum_q;
`else
   assign checksum = '0;
`endif

endmodule
